// File: rtl/wave_ibuf_ctrl.sv
// wave_ibuf_ctrl
//   Queue controller for one wavefront's 8 x 64-bit instruction buffer. It
//   drives the write and read ports of an external 8x64b 1R1W register file
//   and presents the head entry to issue with a valid/ready handshake.
//   Flushes advance a 1-bit epoch. Fetch returns carrying a stale epoch are
//   accepted but dropped.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   fetch_valid/_data/_epoch, fetch_ready   fetch return handshake
//   fetch_req            registered request for more instructions
//   flush                discard buffered words, toggle epoch
//   issue_valid/_data/_ready                head-entry issue handshake
//   rf_wr_en/_addr/_data register-file write port (tail pointer)
//   rf_rd_addr/_data     register-file read port (head pointer)
//   ibuf_count           occupancy 0..8
//   cur_epoch            current epoch
module wave_ibuf_ctrl #(
  parameter int unsigned LOW_WATER = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [63:0] fetch_data,
  input  logic        fetch_epoch,
  output logic        fetch_ready,
  output logic        fetch_req,
  input  logic        flush,
  output logic        issue_valid,
  output logic [63:0] issue_data,
  input  logic        issue_ready,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_addr,
  output logic [63:0] rf_wr_data,
  output logic [2:0]  rf_rd_addr,
  input  logic [63:0] rf_rd_data,
  output logic [3:0]  ibuf_count,
  output logic        cur_epoch
);

  logic [2:0] r_head;
  logic [2:0] r_tail;
  logic [3:0] r_count;
  logic       r_epoch;
  logic       r_fetch_req;

  logic       w_full;
  logic       w_accept;
  logic       w_write;
  logic       w_pop;
  logic [3:0] w_count_next;

  // Full blocks returns even if a pop happens in the same cycle.
  assign w_full      = (r_count == 4'd8);
  assign fetch_ready = ~w_full & ~flush & ~rst;
  assign w_accept    = fetch_valid & fetch_ready;
  // A stale-epoch return completes its handshake but is never written.
  assign w_write     = w_accept & (fetch_epoch == r_epoch);

  // The head is read from the registered count, so a word written this
  // cycle cannot be issued until the next cycle.
  assign issue_valid = (r_count != '0) & ~flush;
  assign w_pop       = issue_valid & issue_ready;

  assign rf_wr_en    = w_write;
  assign rf_wr_addr  = r_tail;
  assign rf_wr_data  = fetch_data;
  assign rf_rd_addr  = r_head;
  assign issue_data  = rf_rd_data;
  assign ibuf_count  = r_count;
  assign cur_epoch   = r_epoch;
  assign fetch_req   = r_fetch_req;

  always_comb begin
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + {3'b000, w_write} - {3'b000, w_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_epoch     <= 1'b0;
      r_fetch_req <= 1'b1;
    end else begin
      r_count     <= w_count_next;
      r_fetch_req <= (w_count_next <= 4'(LOW_WATER));
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_epoch <= ~r_epoch;
      end else begin
        if (w_write) r_tail <= r_tail + 3'd1;
        if (w_pop)   r_head <= r_head + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_wave_ibuf_ctrl.sv
module tb_wave_ibuf_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [63:0] fetch_data;
  logic        fetch_epoch;
  logic        fetch_ready;
  logic        fetch_req;
  logic        flush;
  logic        issue_valid;
  logic [63:0] issue_data;
  logic        issue_ready;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [63:0] rf_wr_data;
  logic [2:0]  rf_rd_addr;
  logic [63:0] rf_rd_data;
  logic [3:0]  ibuf_count;
  logic        cur_epoch;

  int n_chk = 0;
  int n_err = 0;

  // expected writes (addr, data) and expected issue order
  logic [2:0]  wq_addr[$];
  logic [63:0] wq_data[$];
  logic [63:0] iq[$];
  logic [2:0]  exp_tail;

  // 8x64 register file model, combinational read
  logic [63:0] mem [8];

  wave_ibuf_ctrl #(.LOW_WATER(2)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_epoch(fetch_epoch),
    .fetch_ready(fetch_ready), .fetch_req(fetch_req), .flush(flush),
    .issue_valid(issue_valid), .issue_data(issue_data), .issue_ready(issue_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .ibuf_count(ibuf_count), .cur_epoch(cur_epoch)
  );

  always @(posedge clk) if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data = mem[rf_rd_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every pop is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wr_en) begin
        if (wq_addr.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_write: got addr=%0d data=%h expected no write at %0t",
                   rf_wr_addr, rf_wr_data, $time);
        end else begin
          chk("wr_addr", 64'(rf_wr_addr), 64'(wq_addr.pop_front()));
          chk("wr_data", rf_wr_data, wq_data.pop_front());
        end
      end
      if (issue_valid && issue_ready) begin
        if (iq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_pop: got data=%h expected no pop at %0t", issue_data, $time);
        end else begin
          chk("issue_data", issue_data, iq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [63:0] fd, input logic fe,
                       input logic fl, input logic ir);
    fetch_valid = fv; fetch_data = fd; fetch_epoch = fe; flush = fl; issue_ready = ir;
  endtask

  // drive a return that must be written this cycle
  task automatic push(input logic [63:0] d, input logic e, input logic ir);
    drive(1'b1, d, e, 1'b0, ir);
    wq_addr.push_back(exp_tail);
    wq_data.push_back(d);
    iq.push_back(d);
    exp_tail = exp_tail + 3'd1;
  endtask

  task automatic clear_sb();
    wq_addr.delete(); wq_data.delete(); iq.delete();
    exp_tail = 3'd0;
  endtask

  initial begin
    exp_tail = 3'd0;
    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_wr_en",       64'(rf_wr_en),    64'd0);
    chk("rst_fetch_req",   64'(fetch_req),   64'd1);
    chk("rst_count",       64'(ibuf_count),  64'd0);
    #10 rst = 1'b0;
    #1;
    chk("post_rst_ready",  64'(fetch_ready), 64'd1);
    chk("post_rst_epoch",  64'(cur_epoch),   64'd0);
    tick();

    // three words, no issue
    push(64'h11, 1'b0, 1'b0);
    @(negedge clk); chk("t1_ready", 64'(fetch_ready), 64'd1);
    tick();
    push(64'h22, 1'b0, 1'b0);
    @(negedge clk); chk("t1_cnt1", 64'(ibuf_count), 64'd1); chk("t1_req1", 64'(fetch_req), 64'd1);
    tick();
    push(64'h33, 1'b0, 1'b0);
    @(negedge clk); chk("t1_cnt2", 64'(ibuf_count), 64'd2); chk("t1_req2", 64'(fetch_req), 64'd1);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_cnt3", 64'(ibuf_count), 64'd3);
    chk("t1_req3", 64'(fetch_req), 64'd0);
    chk("t1_head", issue_data, 64'h11);
    chk("t1_ivalid", 64'(issue_valid), 64'd1);
    tick();

    // fill to 8
    for (int i = 4; i <= 8; i++) begin
      push(64'(i * 'h11), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 64'h99, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_cnt", 64'(ibuf_count), 64'd8);
    chk("full_ready", 64'(fetch_ready), 64'd0);
    tick();
    // pop while full: still not ready, no write
    drive(1'b1, 64'h99, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk("full_pop_ready", 64'(fetch_ready), 64'd0);
    tick();
    push(64'h99, 1'b0, 1'b0);
    @(negedge clk);
    chk("after_pop_cnt", 64'(ibuf_count), 64'd7);
    chk("wrap_wr_addr", 64'(rf_wr_addr), 64'd0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("refull_cnt", 64'(ibuf_count), 64'd8);
    tick();

    // drain to 4, then 10 cycles of write+pop
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      push(64'hA0 + 64'(i), 1'b0, 1'b1);
      @(negedge clk); chk("steady_cnt", 64'(ibuf_count), 64'd4);
      tick();
    end

    // drain to empty, then write+issue_ready on empty
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    push(64'hB1, 1'b0, 1'b1);
    @(negedge clk);
    chk("empty_cnt", 64'(ibuf_count), 64'd0);
    chk("empty_ivalid", 64'(issue_valid), 64'd0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bypass_ivalid", 64'(issue_valid), 64'd1);
    chk("bypass_data", issue_data, 64'hB1);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    tick();

    // five words, then flush with a return pending
    for (int i = 1; i <= 5; i++) begin
      push(64'hC0 + 64'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 64'hDD, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_cnt_before", 64'(ibuf_count), 64'd5);
    chk("flush_ready", 64'(fetch_ready), 64'd0);
    chk("flush_ivalid", 64'(issue_valid), 64'd0);
    tick();
    clear_sb();
    drive(1'b1, 64'hEE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_cnt", 64'(ibuf_count), 64'd0);
    chk("flush_epoch", 64'(cur_epoch), 64'd1);
    chk("flush_req", 64'(fetch_req), 64'd1);
    chk("flush_head", 64'(rf_rd_addr), 64'd0);
    chk("stale_ready", 64'(fetch_ready), 64'd1);
    chk("stale_wr_en", 64'(rf_wr_en), 64'd0);
    tick();
    push(64'hF1, 1'b1, 1'b0);
    @(negedge clk); chk("new_epoch_addr", 64'(rf_wr_addr), 64'd0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("new_epoch_cnt", 64'(ibuf_count), 64'd1);
    chk("new_epoch_data", issue_data, 64'hF1);
    tick();

    // back-to-back flushes
    drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    @(negedge clk); chk("b2b_epoch0", 64'(cur_epoch), 64'd0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    clear_sb();
    @(negedge clk); chk("b2b_epoch1", 64'(cur_epoch), 64'd1);
    tick();

    // six words then asynchronous reset mid-cycle
    for (int i = 1; i <= 6; i++) begin
      push(64'hD0 + 64'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 64'h123, 1'b1, 1'b0, 1'b1);
    #1;
    chk("pre_rst_cnt", 64'(ibuf_count), 64'd6);
    chk("pre_rst_wr_en", 64'(rf_wr_en), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_ivalid", 64'(issue_valid), 64'd0);
    chk("async_ready", 64'(fetch_ready), 64'd0);
    chk("async_wr_en", 64'(rf_wr_en), 64'd0);
    chk("async_cnt", 64'(ibuf_count), 64'd0);
    clear_sb();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rel_cnt", 64'(ibuf_count), 64'd0);
    chk("rel_epoch", 64'(cur_epoch), 64'd0);
    chk("rel_req", 64'(fetch_req), 64'd1);
    tick();
    tick();
    chk("sb_wr_drained", 64'(wq_addr.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
